mandel_iter: RTL and testbench

Escape-time iteration engine for one pixel. It accepts a complex point c, iterates z ← z² + c from z = 0, and reports the iteration count at escape or at a run-time limit. The block sits directly upstream of the `pipeline_mult` stage: it drives three `pipeline_mult` instances (x·x, y·y, x·y) and consumes their registered products. Results go downstream to the colour/pixel-write stage.

---
 rtl/mandel_iter.sv | 174 +++++++++++++++++
 tb/tb_mandel_iter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mandel_iter.sv
// ============================================================================
// Module   : mandel_iter (with its pipeline_mult multiplier stage)
// Brief    : Escape-time z <- z^2 + c iteration engine for a single pixel.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_mult #(
  parameter int WIDTH = 27
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic signed [WIDTH-1:0]   a,
  input  logic signed [WIDTH-1:0]   b,
  output logic signed [2*WIDTH-1:0] p
);
  logic signed [WIDTH-1:0]   r_a, r_b;
  logic signed [2*WIDTH-1:0] r_p;

  // Two-stage pipeline: operand capture, then full-width product.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_a <= '0;
      r_b <= '0;
      r_p <= '0;
    end else begin
      r_a <= a;
      r_b <= b;
      r_p <= (2*WIDTH)'(r_a) * (2*WIDTH)'(r_b);
    end
  end

  assign p = r_p;
endmodule

module mandel_iter #(
  parameter int INT_BITS  = 4,
  parameter int FRAC_BITS = 23,
  parameter int ITER_BITS = 16
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic signed [INT_BITS+FRAC_BITS-1:0] cx,
  input  logic signed [INT_BITS+FRAC_BITS-1:0] cy,
  input  logic [ITER_BITS-1:0]                 max_iter,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [ITER_BITS-1:0]                 iter,
  output logic                                 escaped
);
  localparam int NB = INT_BITS + FRAC_BITS;
  localparam int WB = NB + 2;

  localparam logic signed [NB-1:0] c_two     = {{(INT_BITS-2){1'b0}}, 2'b10, {FRAC_BITS{1'b0}}};
  localparam logic signed [NB-1:0] c_neg_two = {{(INT_BITS-1){1'b1}}, 1'b0, {FRAC_BITS{1'b0}}};
  localparam logic signed [NB:0]   c_four    = {{(INT_BITS-2){1'b0}}, 3'b100, {FRAC_BITS{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT1 = 3'd1,
    S_WAIT2 = 3'd2,
    S_EVAL  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                r_state, w_next;
  logic signed [NB-1:0]  r_x, r_y, r_cx, r_cy;
  logic [ITER_BITS-1:0]  r_lim, r_count, r_iter;
  logic                  r_escaped;

  logic                  w_mult_rst;
  logic signed [2*NB-1:0] w_pxx, w_pyy, w_pxy;
  logic signed [NB-1:0]  w_xx, w_yy, w_xy;
  logic signed [NB:0]    w_sum;
  logic signed [WB-1:0]  w_nx, w_ny;
  logic                  w_escape, w_at_limit;
  logic                  w_unused;

  function automatic logic signed [NB-1:0] sat(input logic signed [WB-1:0] v);
    if (v[WB-1:NB-1] == 3'b000 || v[WB-1:NB-1] == 3'b111)
      return v[NB-1:0];
    else if (v[WB-1])
      return {1'b1, {(NB-1){1'b0}}};
    else
      return {1'b0, {(NB-1){1'b1}}};
  endfunction

  assign w_mult_rst = ~reset;

  pipeline_mult #(.WIDTH(NB)) u_mult_xx (.clock(clock), .reset(w_mult_rst), .a(r_x), .b(r_x), .p(w_pxx));
  pipeline_mult #(.WIDTH(NB)) u_mult_yy (.clock(clock), .reset(w_mult_rst), .a(r_y), .b(r_y), .p(w_pyy));
  pipeline_mult #(.WIDTH(NB)) u_mult_xy (.clock(clock), .reset(w_mult_rst), .a(r_x), .b(r_y), .p(w_pxy));

  // Rescale products back to the working fixed-point format.
  assign w_xx = w_pxx[NB+FRAC_BITS-1:FRAC_BITS];
  assign w_yy = w_pyy[NB+FRAC_BITS-1:FRAC_BITS];
  assign w_xy = w_pxy[NB+FRAC_BITS-1:FRAC_BITS];
  assign w_unused = ^{w_pxx[2*NB-1:NB+FRAC_BITS], w_pxx[FRAC_BITS-1:0],
                      w_pyy[2*NB-1:NB+FRAC_BITS], w_pyy[FRAC_BITS-1:0],
                      w_pxy[2*NB-1:NB+FRAC_BITS], w_pxy[FRAC_BITS-1:0]};

  // Magnitude guards on x/y catch any overflow in the squared terms first.
  assign w_sum      = {w_xx[NB-1], w_xx} + {w_yy[NB-1], w_yy};
  assign w_escape   = (r_x >= c_two) || (r_x <= c_neg_two) ||
                      (r_y >= c_two) || (r_y <= c_neg_two) || (w_sum > c_four);
  assign w_at_limit = (r_count == r_lim);

  assign w_nx = {{2{w_xx[NB-1]}}, w_xx} - {{2{w_yy[NB-1]}}, w_yy} + {{2{r_cx[NB-1]}}, r_cx};
  assign w_ny = {w_xy[NB-1], w_xy, 1'b0} + {{2{r_cy[NB-1]}}, r_cy};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_next = S_WAIT1;
      S_WAIT1: w_next = S_WAIT2;
      S_WAIT2: w_next = S_EVAL;
      S_EVAL:  w_next = (w_escape || w_at_limit) ? S_DONE : S_WAIT1;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_x       <= '0;
      r_y       <= '0;
      r_cx      <= '0;
      r_cy      <= '0;
      r_lim     <= '0;
      r_count   <= '0;
      r_iter    <= '0;
      r_escaped <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_cx    <= cx;
          r_cy    <= cy;
          r_lim   <= max_iter;
          r_x     <= '0;
          r_y     <= '0;
          r_count <= '0;
        end
        S_EVAL: begin
          if (w_escape) begin
            r_iter    <= r_count;
            r_escaped <= 1'b1;
          end else if (w_at_limit) begin
            r_iter    <= r_lim;
            r_escaped <= 1'b0;
          end else begin
            r_x     <= sat(w_nx);
            r_y     <= sat(w_ny);
            r_count <= r_count + ITER_BITS'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign iter      = r_iter;
  assign escaped   = r_escaped;
endmodule

`default_nettype wire

// File: tb/tb_mandel_iter.sv
// ============================================================================
// Module   : tb_mandel_iter
// Brief    : Directed self-checking bench for mandel_iter (Q4.23 default).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mandel_iter;
  localparam int NB = 27;

  localparam logic signed [NB-1:0] V_0   = 27'sd0;
  localparam logic signed [NB-1:0] V_2P5 = 27'sd20971520;
  localparam logic signed [NB-1:0] V_0P5 = 27'sd4194304;
  localparam logic signed [NB-1:0] V_M1  = -27'sd8388608;
  localparam logic signed [NB-1:0] V_7P9 = 27'sd66270003;
  localparam logic signed [NB-1:0] V_M8  = 27'h4000000;

  logic                 clock = 1'b0;
  logic                 reset;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [NB-1:0] cx, cy;
  logic [15:0]          max_iter;
  logic                 out_valid;
  logic                 out_ready;
  logic [15:0]          iter;
  logic                 escaped;

  int n_cmp = 0;
  int n_bad = 0;

  mandel_iter dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .cx(cx), .cy(cy), .max_iter(max_iter),
    .out_valid(out_valid), .out_ready(out_ready),
    .iter(iter), .escaped(escaped)
  );

  always #5 clock = ~clock;

  // Present a point, then count edges from the accept edge until out_valid.
  task automatic run_point(input string name, input logic signed [NB-1:0] px,
                           input logic signed [NB-1:0] py, input logic [15:0] pm,
                           input int exp_lat, input logic [15:0] exp_iter,
                           input logic exp_esc);
    int  lat;
    bit  got;
    @(negedge clock);
    cx = px; cy = py; max_iter = pm; in_valid = 1'b1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL %s.in_ready: got %b want 1", name, in_ready);
    end
    @(posedge clock); #1;
    in_valid = 1'b0;
    lat = 0; got = 1'b0;
    while (!got && lat < 400) begin
      @(posedge clock); #1;
      lat++;
      if (out_valid === 1'b1) got = 1'b1;
    end
    n_cmp++;
    if (lat != exp_lat || !got) begin
      n_bad++; $display("FAIL %s.latency: got %0d want %0d", name, lat, exp_lat);
    end
    n_cmp++;
    if (iter !== exp_iter) begin
      n_bad++; $display("FAIL %s.iter: got %0d want %0d", name, iter, exp_iter);
    end
    n_cmp++;
    if (escaped !== exp_esc) begin
      n_bad++; $display("FAIL %s.escaped: got %b want %b", name, escaped, exp_esc);
    end
  endtask

  task automatic take_result(input string name);
    @(negedge clock);
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++; $display("FAIL %s.handshake: got out_valid=%b in_ready=%b want 0/1",
                        name, out_valid, in_ready);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    cx = V_0; cy = V_0; max_iter = 16'd0;
    repeat (3) @(posedge clock);
    #1;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || iter !== 16'd0 || escaped !== 1'b0) begin
      n_bad++; $display("FAIL reset_state: got rdy=%b vld=%b iter=%0d esc=%b want 1/0/0/0",
                        in_ready, out_valid, iter, escaped);
    end
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_escape;
    run_point("esc_2p5", V_2P5, V_0, 16'd100, 6, 16'd1, 1'b1);
    take_result("esc_2p5");
    run_point("esc_0p5", V_0P5, V_0, 16'd100, 18, 16'd5, 1'b1);
    take_result("esc_0p5");
  endtask

  task automatic test_reset_mid;
    @(negedge clock);
    cx = V_0P5; cy = V_0; max_iter = 16'd100; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    @(posedge clock); #2;
    reset = 1'b0;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || iter !== 16'd0 || escaped !== 1'b0) begin
      n_bad++; $display("FAIL reset_mid: got rdy=%b vld=%b iter=%0d esc=%b want 1/0/0/0",
                        in_ready, out_valid, iter, escaped);
    end
    @(negedge clock);
    reset = 1'b1;
    run_point("after_reset", V_2P5, V_0, 16'd100, 6, 16'd1, 1'b1);
    take_result("after_reset");
  endtask

  task automatic test_limit;
    run_point("orbit_m1", V_M1, V_0, 16'd10, 33, 16'd10, 1'b0);
    take_result("orbit_m1");
    run_point("zero_limit", V_0, V_0, 16'd0, 3, 16'd0, 1'b0);
    take_result("zero_limit");
  endtask

  task automatic test_saturation;
    run_point("big_pos", V_7P9, V_7P9, 16'd100, 6, 16'd1, 1'b1);
    take_result("big_pos");
    run_point("big_neg", V_M8, V_M8, 16'd100, 6, 16'd1, 1'b1);
    take_result("big_neg");
  endtask

  task automatic test_back_pressure;
    int bad_cycles;
    run_point("bp", V_0P5, V_0, 16'd100, 18, 16'd5, 1'b1);
    bad_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      in_valid = i[0];
      cx = V_M1; max_iter = 16'd0;
      @(posedge clock); #1;
      n_cmp++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || iter !== 16'd5 || escaped !== 1'b1) begin
        n_bad++; bad_cycles++;
        $display("FAIL bp_hold[%0d]: got vld=%b rdy=%b iter=%0d esc=%b want 1/0/5/1",
                 i, out_valid, in_ready, iter, escaped);
      end
    end
    in_valid = 1'b0;
    take_result("bp");
  endtask

  task automatic test_back_to_back;
    run_point("b2b_a", V_2P5, V_0, 16'd100, 6, 16'd1, 1'b1);
    take_result("b2b_a");
    run_point("b2b_b", V_0, V_0, 16'd0, 3, 16'd0, 1'b0);
    take_result("b2b_b");
  endtask

  initial begin
    test_reset;
    test_escape;
    test_reset_mid;
    test_limit;
    test_saturation;
    test_back_pressure;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

`default_nettype wire
